// File: rtl/can_pkg.sv
// Shared definitions for the CAN CRC-15 logic: CRC width, generator
// polynomial and the sequencer state encoding.
package can_pkg;

  localparam int unsigned CAN_CRC_W = 15;

  // x^15+x^14+x^10+x^8+x^7+x^4+x^3+1, with the implicit x^15 term dropped.
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } crc_seq_state_t;

endpackage : can_pkg

// File: rtl/can_crc15_step.sv
// One serial CRC-15 step: shifts a single bit into the CRC register value.
// Purely combinational.
//   crc_in   : current CRC register value
//   bit_i    : incoming bit
//   crc_next : CRC register value after absorbing bit_i
module can_crc15_step
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY = CAN_CRC_POLY
) (
  input  logic [CAN_CRC_W-1:0] crc_in,
  input  logic                 bit_i,
  output logic [CAN_CRC_W-1:0] crc_next
);

  logic fb;

  // Feedback is the incoming bit XOR the bit about to fall off the top.
  assign fb       = bit_i ^ crc_in[CAN_CRC_W-1];
  assign crc_next = {crc_in[CAN_CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule : can_crc15_step

// File: rtl/can_crc_sequencer.sv
// CAN CRC-15 sequencer for one frame. Accumulates the covered (destuffed)
// bits, then either serialises the CRC MSB first (TX) or compares the next
// 15 received bits against it (RX).
//   clk, rst          : clock, asynchronous active-high reset
//   start, mode, len  : begin a frame (mode 0=TX, 1=RX; len covered bits)
//   abort             : drop the current frame, no done pulse
//   bit_valid, bit_in : one destuffed bit per strobe
//   bit_out, bit_out_en : TX CRC bit stream
//   busy, done        : activity / one-cycle completion pulse
//   crc_err           : sticky RX mismatch flag
//   crc_value         : CRC computed over the covered bits
module can_crc_sequencer
  import can_pkg::*;
#(
  parameter int unsigned          LEN_W = 7,
  parameter logic [CAN_CRC_W-1:0] POLY  = CAN_CRC_POLY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [LEN_W-1:0]     len,
  input  logic                 abort,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 bit_out,
  output logic                 bit_out_en,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_err,
  output logic [CAN_CRC_W-1:0] crc_value
);

  crc_seq_state_t       state_q, state_d;
  logic                 mode_q, mode_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [CAN_CRC_W-1:0] crc_q, crc_d;
  logic [CAN_CRC_W-1:0] crc_value_q, crc_value_d;
  logic                 crc_err_q, crc_err_d;

  logic [CAN_CRC_W-1:0] crc_step;
  logic [3:0]           bit_idx;
  logic                 cur_bit;

  can_crc15_step #(.POLY(POLY)) u_step (
    .crc_in   (crc_q),
    .bit_i    (bit_in),
    .crc_next (crc_step)
  );

  // In CRC state cnt runs 0..14, selecting crc_value bits 14 down to 0.
  assign bit_idx = 4'd14 - cnt_q[3:0];
  assign cur_bit = crc_value_q[bit_idx];

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    crc_value_d = crc_value_q;
    crc_err_d   = crc_err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          len_d       = len;
          cnt_d       = '0;
          crc_d       = '0;
          crc_value_d = '0;
          crc_err_d   = 1'b0;
          state_d     = (len == '0) ? CRC : DATA;
        end
      end

      DATA: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_valid) begin
          crc_d = crc_step;
          if (cnt_q == len_q - LEN_W'(1)) begin
            crc_value_d = crc_step;
            cnt_d       = '0;
            state_d     = CRC;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end

      CRC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_valid) begin
          if (mode_q && (bit_in != cur_bit)) begin
            crc_err_d = 1'b1;
          end
          if (cnt_q == LEN_W'(CAN_CRC_W - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      crc_q       <= '0;
      crc_value_q <= '0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      crc_value_q <= crc_value_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign bit_out_en = (state_q == CRC) && !mode_q;
  assign bit_out    = bit_out_en & cur_bit;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign crc_err    = crc_err_q;
  assign crc_value  = crc_value_q;

endmodule : can_crc_sequencer

// File: tb/tb_can_crc_sequencer.sv
// Directed bench for can_crc_sequencer with hand-computed CRC values.
module tb_can_crc_sequencer;

  localparam int LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             bit_valid;
  logic             bit_in;
  logic             bit_out;
  logic             bit_out_en;
  logic             busy;
  logic             done;
  logic             crc_err;
  logic [14:0]      crc_value;

  int n_vec  = 0;
  int n_miss = 0;

  can_crc_sequencer #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .len        (len),
    .abort      (abort),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_out    (bit_out),
    .bit_out_en (bit_out_en),
    .busy       (busy),
    .done       (done),
    .crc_err    (crc_err),
    .crc_value  (crc_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read in between.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [LEN_W-1:0] l);
    start = 1'b1;
    mode  = m;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  logic [14:0] exp_crc;
  logic [14:0] rx_bits;
  int          en_cnt;
  int          strobes;
  logic        seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
    abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", bit_out_en, 0);
    check("rst_out", bit_out, 0);
    check("rst_err", crc_err, 0);
    check("rst_crc", crc_value, 0);

    // TX len=1, bit 1 -> 0x4599, serialised MSB first
    do_start(1'b0, 7'd1);
    check("tx1_busy", busy, 1);
    strobe(1'b1);
    check("tx1_crc", crc_value, 15'h4599);
    exp_crc = 15'b100_0101_1001_1001;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("tx1_en%0d", i), bit_out_en, 1);
      check($sformatf("tx1_bit%0d", i), bit_out, exp_crc[14-i]);
      check($sformatf("tx1_nodone%0d", i), done, 0);
      strobe(1'b0);
    end
    check("tx1_done", done, 1);
    check("tx1_done_busy", busy, 1);
    check("tx1_done_en", bit_out_en, 0);
    tick();
    check("tx1_done_pulse", done, 0);
    check("tx1_idle", busy, 0);
    check("tx1_crc_hold", crc_value, 15'h4599);

    // TX len=2, bits 1,0 -> 0x4EAB, bit_out_en for exactly 15 strobes
    do_start(1'b0, 7'd2);
    strobe(1'b1);
    strobe(1'b0);
    check("tx2_crc", crc_value, 15'h4EAB);
    en_cnt = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (bit_out_en) en_cnt++;
      if (done) seen_done = 1'b1;
      else strobe(1'b0);
    end
    check("tx2_en_count", en_cnt, 15);
    check("tx2_done_seen", seen_done, 1);
    tick();

    // RX len=2, correct CRC
    do_start(1'b1, 7'd2);
    strobe(1'b1);
    strobe(1'b0);
    check("rx2_crc", crc_value, 15'h4EAB);
    check("rx2_en_low", bit_out_en, 0);
    rx_bits = 15'h4EAB;
    for (int i = 14; i >= 0; i--) strobe(rx_bits[i]);
    check("rx2_done", done, 1);
    check("rx2_err", crc_err, 0);
    tick();

    // RX len=2, CRC bit 5 flipped -> sticky error
    do_start(1'b1, 7'd2);
    strobe(1'b1);
    strobe(1'b0);
    rx_bits = 15'h4EAB ^ 15'h0020;
    for (int i = 14; i >= 0; i--) strobe(rx_bits[i]);
    check("rx2b_done", done, 1);
    check("rx2b_err", crc_err, 1);
    repeat (3) tick();
    check("rx2b_idle", busy, 0);
    check("rx2b_err_hold", crc_err, 1);
    strobe(1'b1);
    check("rx2b_idle_strobe", busy, 0);
    check("rx2b_err_hold2", crc_err, 1);

    // RX len=8, all zeros; an extra start while busy must not relatch len
    do_start(1'b1, 7'd8);
    check("rx8_err_cleared", crc_err, 0);
    check("rx8_crc_cleared", crc_value, 0);
    strobe(1'b0);
    strobe(1'b0);
    do_start(1'b0, 7'd3);
    strobes = 2;
    seen_done = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (done) seen_done = 1'b1;
      else begin
        strobe(1'b0);
        strobes++;
      end
    end
    check("rx8_done_seen", seen_done, 1);
    check("rx8_strobes", strobes, 23);
    check("rx8_crc", crc_value, 0);
    check("rx8_err", crc_err, 0);
    tick();

    // Abort in DATA after 3 bits
    do_start(1'b0, 7'd8);
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    abort = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    check("abort_pre_busy", busy, 1);
    tick();
    abort = 1'b0;
    bit_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick();
    check("abort_done2", done, 0);
    do_start(1'b0, 7'd1);
    strobe(1'b1);
    check("abort_restart_crc", crc_value, 15'h4599);
    check("abort_restart_en", bit_out_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_crc_busy", busy, 0);

    // len=0 goes straight to CRC with a zero CRC
    do_start(1'b0, 7'd0);
    check("len0_en", bit_out_en, 1);
    check("len0_crc", crc_value, 0);
    check("len0_out", bit_out, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset mid-CRC
    do_start(1'b0, 7'd1);
    strobe(1'b1);
    strobe(1'b0);
    check("rst_mid_pre", bit_out_en, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_en", bit_out_en, 0);
    check("rst_mid_out", bit_out, 0);
    check("rst_mid_crc", crc_value, 0);
    check("rst_mid_err", crc_err, 0);
    check("rst_mid_done", done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) strobe(1'b1);
    check("rst_post_busy", busy, 0);
    check("rst_post_crc", crc_value, 0);
    check("rst_post_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_can_crc_sequencer

// File: doc/can_crc_sequencer.md
Name: can_crc_sequencer

Overview:
- Sequences CAN CRC-15 generation and checking over one frame's bit stream.
- Sits between the bit-timing/bit-stuffing layer and the frame FSM.
- In TX mode, accumulates the covered bits (SOF through data field), then serialises the 15-bit CRC onto bit_out.
- In RX mode, accumulates the covered bits, then compares the next 15 received bits against the computed CRC and flags a mismatch.

Parameters:
- LEN_W, 7, width of the covered-bit-count input (max 2^LEN_W-1 covered bits).
- POLY, 15'h4599, CRC-15 generator polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 without the x^15 term.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begin a frame. Ignored unless IDLE.
- mode  input  1  0 = TX generate, 1 = RX check; sampled on start.
- len  input  LEN_W  number of covered (destuffed) bits; sampled on start.
- abort  input  1  synchronous abort (error frame or arbitration lost).
- bit_valid  input  1  one-cycle strobe per destuffed bit time.
- bit_in  input  1  destuffed bit; qualified by bit_valid.
- bit_out  output  1  TX CRC bit, MSB first; valid when bit_out_en=1.
- bit_out_en  output  1  high in CRC state with mode=0.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on frame completion.
- crc_err  output  1  RX mismatch flag; sticky until next accepted start.
- crc_value  output  15  computed CRC; holds from CRC-state entry until next accepted start.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; crc register, cnt, crc_value all zero; bit_out, bit_out_en, busy, done, crc_err all 0.
- Reset asserted mid-frame gives the same result immediately; no done pulse is produced.
- CRC step, applied on a bit_valid in DATA state only: fb = bit_in ^ crc[14]; crc <= {crc[13:0],0} ^ (fb ? POLY : 0). Register updates at the clock edge that samples bit_valid (1-cycle latency).
- States: IDLE, DATA, CRC, DONE.
- IDLE:
  - start=1: latch mode and len; clear crc, cnt, crc_err.
  - Go to DATA, or directly to CRC if len==0 (crc_value=0 in that case).
- DATA:
  - Each bit_valid applies a CRC step and increments cnt.
  - On the bit_valid where cnt==len-1: crc_value <= post-step crc; cnt <= 0; go to CRC.
- CRC state, cnt indexes bit (14-cnt) of crc_value.
  - TX (mode=0): bit_out = crc_value[14-cnt] combinationally; bit_out_en=1.
  - RX (mode=1): on each bit_valid, if bit_in != crc_value[14-cnt], set crc_err.
  - Each bit_valid increments cnt. The bit_valid with cnt==14 moves to DONE.
- DONE: done=1 for exactly one cycle; busy=1; then IDLE. crc_err and crc_value hold.
- abort (any non-IDLE state): go to IDLE next cycle with no done pulse. abort takes priority over bit_valid in the same cycle. crc_err is left unchanged.
- start while busy is ignored; a start coinciding with abort is ignored.
- bit_valid in IDLE or DONE is ignored.
- Counter cnt is LEN_W bits wide and never wraps: its terminal compare always fires first.

Decomposition:
- Shared package can_pkg:
  - CAN_CRC_W=15.
  - CAN_CRC_POLY=15'h4599.
  - Enum crc_seq_state_t {IDLE, DATA, CRC, DONE}.
- Sub-module can_crc15_step: purely combinational; inputs crc_in[14:0] and bit; output crc_next. Reused by the frame checker and the testbench model.

Test Plan:
- TX, len=1, bit "1" -> crc_value=15'h4599. bit_out over 15 bit_valids = 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1. done pulses 1 cycle after the 15th strobe.
- TX, len=2, bits "1","0" -> crc_value=15'h4EAB. bit_out_en high for exactly 15 strobes.
- RX, len=2, bits "1","0", then CRC bits of 0x4EAB -> crc_err=0, done=1. Repeat with CRC bit 5 flipped -> crc_err=1, holds until next start.
- RX, len=8, all-zero data, then 15 zeros -> crc_value=0, crc_err=0. A start pulse while busy is ignored (len is not relatched).
- abort during DATA after 3 bits -> IDLE next cycle, no done, busy=0. Then a new start with len=1 and bit "1" -> crc_value=15'h4599.
- rst pulse during CRC state, asynchronous mid-cycle -> all outputs 0 immediately. bit_valid strobes afterwards have no effect until start.
